me_scan_feeder: RTL and testbench

//   Drives one motion-estimation systolic array (MACRO_DIM pe_col columns) for a full-search

---
 rtl/me_scan_feeder.sv | 233 +++++++++++++++++++++++
 tb/tb_me_scan_feeder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_scan_feeder.sv
// Sequencer for one full-search motion-estimation systolic array: issues RAM reads,
// array enables and shift selects along a snake scan, and tags each settled candidate.
module me_scan_feeder #(
    parameter int MACRO_DIM = 16,
    parameter int RANGE     = 8,
    localparam int SW = MACRO_DIM + 2 * RANGE,
    localparam int CW = $clog2(2 * RANGE + 1),
    localparam int AW = $clog2(SW),
    localparam int RW = (MACRO_DIM > 1) ? $clog2(MACRO_DIM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     cur_rd,
    output logic [RW-1:0]            cur_row,
    input  logic [MACRO_DIM*8-1:0]   cur_data,
    output logic                     srch_rd,
    output logic                     srch_row_mode,
    output logic [AW-1:0]            srch_x,
    output logic [AW-1:0]            srch_y,
    input  logic [MACRO_DIM*8-1:0]   srch_data,
    output logic [MACRO_DIM*8-1:0]   arr_cpr,
    output logic [MACRO_DIM*8-1:0]   arr_spr_top,
    output logic [MACRO_DIM*8-1:0]   arr_spr_right,
    output logic                     en_cpr,
    output logic                     en_spr,
    output logic [1:0]               sel,
    output logic                     cand_valid,
    output logic [CW-1:0]            cand_dx,
    output logic [CW-1:0]            cand_dy
);

    localparam int JW = $clog2(MACRO_DIM + 2 * RANGE) + 1;
    localparam logic [JW-1:0] LOAD_LAST  = JW'(MACRO_DIM - 1);
    localparam logic [JW-1:0] SWEEP_LAST = JW'(2 * RANGE - 1);
    localparam logic [JW-1:0] FLUSH_LAST = JW'(1);
    localparam logic [CW-1:0] D_MAX      = CW'(2 * RANGE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SWEEP  = 3'd2,
        S_LSHIFT = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [JW-1:0] step_r, step_s;
    logic [CW-1:0] dx_r, dx_s;
    logic [CW-1:0] dy_r, dy_s;

    // Values issued this cycle, aligned to RAM data by the pipeline register below
    logic          iss_cpr_s, iss_spr_s, iss_cpl_s, iss_last_s;
    logic [1:0]    iss_sel_s;
    logic [CW-1:0] iss_dx_s, iss_dy_s;

    logic          cpl_r, last_r;
    logic [CW-1:0] tag_dx_r, tag_dy_r;

    assign arr_cpr       = cur_data;
    assign arr_spr_top   = srch_data;
    assign arr_spr_right = srch_data;
    assign busy          = (state_r != S_IDLE);

    // State and scan-position registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            step_r  <= '0;
            dx_r    <= '0;
            dy_r    <= '0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            dx_r    <= dx_s;
            dy_r    <= dy_s;
        end
    end

    // Next-state and scan-position update
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        dx_s    = dx_r;
        dy_s    = dy_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LOAD;
                    step_s  = '0;
                    dx_s    = '0;
                    dy_s    = '0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (step_r == LOAD_LAST) begin
                    state_s = S_SWEEP;
                    step_s  = '0;
                end else begin
                    step_s = step_r + JW'(1);
                end
            end
            S_SWEEP: begin
                // even columns sweep toward larger dy, odd columns back toward 0
                dy_s = dx_r[0] ? (dy_r - CW'(1)) : (dy_r + CW'(1));
                if (step_r == SWEEP_LAST) begin
                    step_s  = '0;
                    state_s = (dx_r == D_MAX) ? S_FLUSH : S_LSHIFT;
                end else begin
                    step_s = step_r + JW'(1);
                end
            end
            S_LSHIFT: begin
                dx_s    = dx_r + CW'(1);
                step_s  = '0;
                state_s = S_SWEEP;
            end
            S_FLUSH: begin
                if (step_r == FLUSH_LAST) begin
                    state_s = S_IDLE;
                    step_s  = '0;
                end else begin
                    step_s = step_r + JW'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                step_s  = '0;
                dx_s    = '0;
                dy_s    = '0;
            end
        endcase
    end

    // RAM addressing and per-cycle shift decode
    always_comb begin
        cur_rd        = 1'b0;
        cur_row       = '0;
        srch_rd       = 1'b0;
        srch_row_mode = 1'b0;
        srch_x        = '0;
        srch_y        = '0;
        iss_cpr_s     = 1'b0;
        iss_spr_s     = 1'b0;
        iss_sel_s     = 2'b11;
        iss_cpl_s     = 1'b0;
        iss_last_s    = 1'b0;
        iss_dx_s      = '0;
        iss_dy_s      = '0;
        case (state_r)
            S_LOAD: begin
                // rows enter bottom-up so row 0 ends at the top of the array
                cur_rd        = 1'b1;
                cur_row       = RW'(MACRO_DIM - 1) - RW'(step_r);
                srch_rd       = 1'b1;
                srch_row_mode = 1'b1;
                srch_y        = AW'(MACRO_DIM - 1) - AW'(step_r);
                iss_cpr_s     = 1'b1;
                iss_spr_s     = 1'b1;
                iss_sel_s     = 2'b00;
                iss_cpl_s     = (step_r == LOAD_LAST);
            end
            S_SWEEP: begin
                srch_rd       = 1'b1;
                srch_row_mode = 1'b1;
                srch_x        = AW'(dx_r);
                iss_spr_s     = 1'b1;
                iss_cpl_s     = 1'b1;
                iss_dx_s      = dx_r;
                iss_last_s    = (dx_r == D_MAX) && (step_r == SWEEP_LAST);
                if (dx_r[0]) begin
                    srch_y    = AW'(dy_r) - AW'(1);
                    iss_sel_s = 2'b00;
                    iss_dy_s  = dy_r - CW'(1);
                end else begin
                    srch_y    = AW'(dy_r) + AW'(MACRO_DIM);
                    iss_sel_s = 2'b01;
                    iss_dy_s  = dy_r + CW'(1);
                end
            end
            S_LSHIFT: begin
                srch_rd   = 1'b1;
                srch_x    = AW'(dx_r) + AW'(MACRO_DIM);
                srch_y    = AW'(dy_r);
                iss_spr_s = 1'b1;
                iss_sel_s = 2'b10;
                iss_cpl_s = 1'b1;
                iss_dx_s  = dx_r + CW'(1);
                iss_dy_s  = dy_r;
            end
            S_IDLE, S_FLUSH: begin
                iss_sel_s = 2'b11;
            end
            default: begin
                iss_sel_s = 2'b11;
            end
        endcase
    end

    // Enables/select follow the read by one cycle; candidate tags follow the enable by one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_cpr     <= 1'b0;
            en_spr     <= 1'b0;
            sel        <= 2'b11;
            cpl_r      <= 1'b0;
            last_r     <= 1'b0;
            tag_dx_r   <= '0;
            tag_dy_r   <= '0;
            cand_valid <= 1'b0;
            cand_dx    <= '0;
            cand_dy    <= '0;
            done       <= 1'b0;
        end else begin
            en_cpr     <= iss_cpr_s;
            en_spr     <= iss_spr_s;
            sel        <= iss_sel_s;
            cpl_r      <= iss_cpl_s;
            last_r     <= iss_last_s;
            tag_dx_r   <= iss_dx_s;
            tag_dy_r   <= iss_dy_s;
            cand_valid <= cpl_r;
            cand_dx    <= tag_dx_r;
            cand_dy    <= tag_dy_r;
            done       <= last_r;
        end
    end

endmodule

// File: tb/tb_me_scan_feeder.sv
// Scoreboard bench: small instance (MD=4,R=2) checked shift-by-shift and candidate-by-candidate,
// default instance (MD=16,R=8) checked for cycle-accurate timing of one search.
module tb_me_scan_feeder;

    localparam int MD = 4;
    localparam int R  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b;

    // small instance
    logic        busy_a, done_a, cur_rd_a, srch_rd_a, srch_row_mode_a;
    logic        en_cpr_a, en_spr_a, cand_valid_a;
    logic [1:0]  cur_row_a, sel_a;
    logic [2:0]  srch_x_a, srch_y_a, cand_dx_a, cand_dy_a;
    logic [31:0] cur_data_a, srch_data_a, arr_cpr_a, arr_spr_top_a, arr_spr_right_a;

    // default instance
    logic         busy_b, done_b, cur_rd_b, srch_rd_b, srch_row_mode_b;
    logic         en_cpr_b, en_spr_b, cand_valid_b;
    logic [3:0]   cur_row_b;
    logic [1:0]   sel_b;
    logic [4:0]   srch_x_b, srch_y_b, cand_dx_b, cand_dy_b;
    logic [127:0] cur_data_b, srch_data_b, arr_cpr_b, arr_spr_top_b, arr_spr_right_b;

    me_scan_feeder #(.MACRO_DIM(MD), .RANGE(R)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .cur_rd(cur_rd_a), .cur_row(cur_row_a), .cur_data(cur_data_a),
        .srch_rd(srch_rd_a), .srch_row_mode(srch_row_mode_a), .srch_x(srch_x_a), .srch_y(srch_y_a),
        .srch_data(srch_data_a), .arr_cpr(arr_cpr_a), .arr_spr_top(arr_spr_top_a),
        .arr_spr_right(arr_spr_right_a), .en_cpr(en_cpr_a), .en_spr(en_spr_a), .sel(sel_a),
        .cand_valid(cand_valid_a), .cand_dx(cand_dx_a), .cand_dy(cand_dy_a)
    );

    me_scan_feeder dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .cur_rd(cur_rd_b), .cur_row(cur_row_b), .cur_data(cur_data_b),
        .srch_rd(srch_rd_b), .srch_row_mode(srch_row_mode_b), .srch_x(srch_x_b), .srch_y(srch_y_b),
        .srch_data(srch_data_b), .arr_cpr(arr_cpr_b), .arr_spr_top(arr_spr_top_b),
        .arr_spr_right(arr_spr_right_b), .en_cpr(en_cpr_b), .en_spr(en_spr_b), .sel(sel_b),
        .cand_valid(cand_valid_b), .cand_dx(cand_dx_b), .cand_dy(cand_dy_b)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic        cpr;
        logic        rm;
        logic [31:0] cdat;
        logic [31:0] sdat;
    } shift_t;

    typedef struct packed {
        logic [2:0] dx;
        logic [2:0] dy;
        logic       last;
    } tag_t;

    shift_t sh_q[$];
    tag_t   tg_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;

    // hand-written select trace for MD=4, R=2
    logic [1:0] sel_exp [28] = '{
        2'd0, 2'd0, 2'd0, 2'd0,  2'd1, 2'd1, 2'd1, 2'd1,  2'd2,
        2'd0, 2'd0, 2'd0, 2'd0,  2'd2,
        2'd1, 2'd1, 2'd1, 2'd1,  2'd2,
        2'd0, 2'd0, 2'd0, 2'd0,  2'd2,
        2'd1, 2'd1, 2'd1, 2'd1
    };

    function automatic logic [31:0] f_cur(input int row);
        return 32'hC0DE_0000 | 32'(row);
    endfunction

    function automatic logic [31:0] f_srch(input bit rm, input int x, input int y);
        return {(rm ? 8'hA5 : 8'h5A), 8'(x), 8'(y), 8'h3C};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (cur_rd_a)  cur_data_a  <= f_cur(int'(cur_row_a));
        if (srch_rd_a) srch_data_a <= f_srch(srch_row_mode_a, int'(srch_x_a), int'(srch_y_a));
    end

    // expected shift and candidate stream of one full search on the small instance
    task automatic push_run();
        int k  = 0;
        int dy = 0;
        for (int j = 0; j < MD; j++) begin
            sh_q.push_back('{sel: sel_exp[k], cpr: 1'b1, rm: 1'b1,
                             cdat: f_cur(MD - 1 - j), sdat: f_srch(1'b1, 0, MD - 1 - j)});
            k++;
        end
        tg_q.push_back('{dx: 3'd0, dy: 3'd0, last: 1'b0});
        for (int dx = 0; dx <= 2 * R; dx++) begin
            for (int s = 0; s < 2 * R; s++) begin
                int y;
                if (dx % 2 == 0) begin
                    y = dy + MD;
                    dy++;
                end else begin
                    y = dy - 1;
                    dy--;
                end
                sh_q.push_back('{sel: sel_exp[k], cpr: 1'b0, rm: 1'b1,
                                 cdat: 32'h0, sdat: f_srch(1'b1, dx, y)});
                k++;
                tg_q.push_back('{dx: 3'(dx), dy: 3'(dy), last: (dx == 2 * R && s == 2 * R - 1)});
            end
            if (dx < 2 * R) begin
                sh_q.push_back('{sel: sel_exp[k], cpr: 1'b0, rm: 1'b0,
                                 cdat: 32'h0, sdat: f_srch(1'b0, dx + MD, dy)});
                k++;
                tg_q.push_back('{dx: 3'(dx + 1), dy: 3'(dy), last: 1'b0});
            end
        end
    endtask

    // monitor: pops expectations whenever the small instance shifts or presents a candidate
    always @(negedge clk) begin : mon
        shift_t e;
        tag_t   t;
        if (mon_on) begin
            if (en_spr_a || en_cpr_a) begin
                if (sh_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL shift_unexpected: sel=%0d with nothing expected", sel_a);
                end else begin
                    e = sh_q.pop_front();
                    check("sel", 64'(sel_a), 64'(e.sel));
                    check("en_cpr", 64'(en_cpr_a), 64'(e.cpr));
                    check("en_spr", 64'(en_spr_a), 64'(1'b1));
                    if (e.cpr) check("arr_cpr", 64'(arr_cpr_a), 64'(e.cdat));
                    if (e.rm) check("arr_spr_top", 64'(arr_spr_top_a), 64'(e.sdat));
                    else      check("arr_spr_right", 64'(arr_spr_right_a), 64'(e.sdat));
                end
            end else begin
                check("sel_idle", 64'(sel_a), 64'(2'b11));
            end
            if (cand_valid_a) begin
                if (tg_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cand_unexpected: got (%0d,%0d) with nothing expected", cand_dx_a, cand_dy_a);
                end else begin
                    t = tg_q.pop_front();
                    check("cand_dx", 64'(cand_dx_a), 64'(t.dx));
                    check("cand_dy", 64'(cand_dy_a), 64'(t.dy));
                    check("done_on_last", 64'(done_a), 64'(t.last));
                end
            end else begin
                check("done_without_valid", 64'(done_a), 64'(1'b0));
            end
        end
    end

    task automatic wait_done_a();
        int  n     = 0;
        bit  found = 1'b0;
        while (n < 200 && !found) begin
            @(negedge clk);
            if (done_a) found = 1'b1;
            n++;
        end
        check("done_seen", 64'(found), 64'(1'b1));
        @(negedge clk);
        check("busy_after_done", 64'(busy_a), 64'(1'b0));
        check("shift_q_empty", 64'(sh_q.size()), 64'(0));
        check("tag_q_empty", 64'(tg_q.size()), 64'(0));
    endtask

    initial begin
        int cr_first, cr_last, ec_first, ec_last, cv_first, cv_last, cv_cnt, done_cyc, busy_low;
        logic [3:0] first_row;
        logic [4:0] f_dx, f_dy, d_dx, d_dy;
        cr_first = -1; cr_last = -1; ec_first = -1; ec_last = -1;
        cv_first = -1; cv_last = -1; cv_cnt = 0; done_cyc = -1; busy_low = -1;
        first_row = '0; f_dx = '0; f_dy = '0; d_dx = '0; d_dy = '0;

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        cur_data_b = '0; srch_data_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_done", 64'(done_a), 64'(0));
        check("rst_cand_valid", 64'(cand_valid_a), 64'(0));
        check("rst_en", 64'({en_cpr_a, en_spr_a}), 64'(0));
        check("rst_sel", 64'(sel_a), 64'(2'b11));
        check("rst_strobes", 64'({cur_rd_a, srch_rd_a}), 64'(0));
        check("rst_addr", 64'({cur_row_a, srch_x_a, srch_y_a}), 64'(0));
        check("rst_cand_tag", 64'({cand_dx_a, cand_dy_a}), 64'(0));
        check("rst_b_busy_sel", 64'({busy_b, sel_b}), 64'(3'b011));
        mon_on = 1'b1;

        // full search with a second start mid-search that must be ignored
        @(posedge clk); #1 start_a = 1'b1;
        push_run();
        @(posedge clk); #1 start_a = 1'b0;
        repeat (18) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        wait_done_a();

        // reset in the middle of a sweep
        mon_on = 1'b0;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("busy_mid_sweep", 64'(busy_a), 64'(1));
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy_a), 64'(0));
        check("midrst_en_spr", 64'(en_spr_a), 64'(0));
        check("midrst_sel", 64'(sel_a), 64'(2'b11));
        check("midrst_valid_done", 64'({cand_valid_a, done_a}), 64'(0));
        check("midrst_srch_rd", 64'(srch_rd_a), 64'(0));
        sh_q.delete();
        tg_q.delete();
        mon_on = 1'b1;

        // clean search after the abort
        @(posedge clk); #1 start_a = 1'b1;
        push_run();
        @(posedge clk); #1 start_a = 1'b0;
        wait_done_a();

        // default-size timing: start high in cycle 0
        @(posedge clk); #1 start_b = 1'b1;
        for (int k = 0; k <= 320; k++) begin
            @(negedge clk);
            if (k == 1) start_b = 1'b0;
            if (k == 0) check("b_busy_c0", 64'(busy_b), 64'(0));
            if (k == 1) check("b_busy_c1", 64'(busy_b), 64'(1));
            if (cur_rd_b) begin
                if (cr_first < 0) begin
                    cr_first  = k;
                    first_row = cur_row_b;
                end
                cr_last = k;
            end
            if (en_cpr_b) begin
                if (ec_first < 0) ec_first = k;
                ec_last = k;
            end
            if (cand_valid_b) begin
                if (cv_first < 0) begin
                    cv_first = k;
                    f_dx = cand_dx_b;
                    f_dy = cand_dy_b;
                end
                cv_last = k;
                cv_cnt++;
            end
            if (done_b) begin
                done_cyc = k;
                d_dx = cand_dx_b;
                d_dy = cand_dy_b;
            end
            if (busy_low < 0 && k > 1 && !busy_b) busy_low = k;
        end
        check("b_cur_rd_first", 64'(cr_first), 64'(1));
        check("b_cur_rd_last", 64'(cr_last), 64'(16));
        check("b_first_row", 64'(first_row), 64'(15));
        check("b_en_cpr_first", 64'(ec_first), 64'(2));
        check("b_en_cpr_last", 64'(ec_last), 64'(17));
        check("b_valid_first", 64'(cv_first), 64'(18));
        check("b_first_tag", 64'({f_dx, f_dy}), 64'(0));
        check("b_valid_count", 64'(cv_cnt), 64'(289));
        check("b_valid_last", 64'(cv_last), 64'(306));
        check("b_done_cycle", 64'(done_cyc), 64'(306));
        check("b_done_tag", 64'({d_dx, d_dy}), 64'({5'd16, 5'd16}));
        check("b_busy_low", 64'(busy_low), 64'(307));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
